// File: rtl/display_tx_ctrl.sv
// display_tx_ctrl
//   Drives the terminal display's single character-input port. Two requesters
//   share it: the CPU TX holding register and a text-injection FIFO, served
//   round-robin. Also runs screen-clear, holding disp_clr_o for whole frames.
// Ports
//   sys_clock, reset          clock, asynchronous active-high reset
//   pixel_clken_i, cpu_clken_i clock enables; the display samples when both are high
//   cpu_we_i/cpu_data_i       CPU write into the holding register
//   cpu_ready_o               holding register empty and not clearing (PB7)
//   inj_valid_i/inj_data_i    injection stream; push = inj_valid_i & inj_ready_o
//   inj_ready_o               FIFO not full and not clearing
//   clr_req_i                 clear request level; rising edge acts
//   vsync_i                   frame start on rising edge
//   disp_ready_i              display ready
//   disp_address_o, disp_w_en_o, disp_din_o, disp_clr_o   display interface
//   busy_o                    presenting a character or clearing
module display_tx_ctrl #(
  parameter int FIFO_AW    = 4,
  parameter int CLR_FRAMES = 2
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       pixel_clken_i,
  input  logic       cpu_clken_i,
  input  logic       cpu_we_i,
  input  logic [7:0] cpu_data_i,
  output logic       cpu_ready_o,
  input  logic       inj_valid_i,
  input  logic [7:0] inj_data_i,
  output logic       inj_ready_o,
  input  logic       clr_req_i,
  input  logic       vsync_i,
  input  logic       disp_ready_i,
  output logic       disp_address_o,
  output logic       disp_w_en_o,
  output logic [7:0] disp_din_o,
  output logic       disp_clr_o,
  output logic       busy_o
);

  localparam int FRM_W = $clog2(CLR_FRAMES + 2);
  localparam logic [FRM_W-1:0]   FRM_LOAD = FRM_W'(CLR_FRAMES + 1);
  localparam logic [FRM_W-1:0]   FRM_ONE  = FRM_W'(1);
  localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(2 ** FIFO_AW);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_PRESENT, ST_CLEAR} state_t;

  state_t           state_q, state_d;
  logic [7:0]       hold_q;
  logic             hold_vld_q, hold_vld_d;
  logic [7:0]       din_q, din_d;
  logic             sel_q, sel_d;     // 1: FIFO is the source being presented
  logic             prio_q, prio_d;   // 1: FIFO wins a tie
  logic             clr_pend_q, clr_pend_d;
  logic [FRM_W-1:0] frm_q, frm_d;
  logic [2:0]       clr_sync_q;
  logic             vs_q;

  logic [7:0]         mem [2**FIFO_AW];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   cnt_q;

  logic clr_edge, vs_rise, accept, cpu_wr, push, pop, flush, fifo_ne, fifo_pick;

  assign clr_edge  = clr_sync_q[1] & ~clr_sync_q[2];
  assign vs_rise   = pixel_clken_i & vsync_i & ~vs_q;
  assign fifo_ne   = (cnt_q != '0);
  assign fifo_pick = (hold_vld_q & fifo_ne) ? prio_q : fifo_ne;
  assign accept    = pixel_clken_i & cpu_clken_i & disp_w_en_o & disp_ready_i;
  assign cpu_wr    = cpu_clken_i & cpu_we_i & cpu_ready_o;
  assign push      = inj_valid_i & inj_ready_o;

  assign cpu_ready_o    = ~hold_vld_q & (state_q != ST_CLEAR);
  assign inj_ready_o    = (cnt_q != FULL_CNT) & (state_q != ST_CLEAR);
  assign disp_w_en_o    = (state_q == ST_PRESENT);
  assign disp_address_o = ~disp_w_en_o;
  assign disp_din_o     = din_q;
  assign disp_clr_o     = (state_q == ST_CLEAR);
  assign busy_o         = disp_w_en_o | disp_clr_o;

  always_comb begin
    state_d    = state_q;
    din_d      = din_q;
    sel_d      = sel_q;
    prio_d     = prio_q;
    frm_d      = frm_q;
    pop        = 1'b0;
    flush      = 1'b0;
    clr_pend_d = clr_pend_q | (clr_edge & (state_q != ST_CLEAR));
    case (state_q)
      ST_IDLE, ST_PRESENT: begin
        if (clr_pend_q) begin
          // A pending clear beats any accept: the presented char is dropped.
          state_d    = ST_CLEAR;
          flush      = 1'b1;
          clr_pend_d = 1'b0;
          frm_d      = FRM_LOAD;
        end else if (state_q == ST_IDLE) begin
          if (hold_vld_q | fifo_ne) begin
            sel_d   = fifo_pick;
            din_d   = fifo_pick ? mem[rd_ptr_q] : hold_q;
            state_d = ST_PRESENT;
          end
        end else if (accept) begin
          pop     = 1'b1;
          prio_d  = ~prio_q;
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        // Exiting on edge CLR_FRAMES+1 guarantees CLR_FRAMES complete frames
        // regardless of where in a frame the clear began.
        if (clr_edge) begin
          frm_d = FRM_LOAD;
        end else if (vs_rise) begin
          frm_d = frm_q - FRM_ONE;
          if (frm_q == FRM_ONE) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hold_vld_d = hold_vld_q;
    if (flush)             hold_vld_d = 1'b0;
    else if (cpu_wr)       hold_vld_d = 1'b1;
    else if (pop & ~sel_q) hold_vld_d = 1'b0;
  end

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      din_q      <= '0;
      sel_q      <= 1'b0;
      prio_q     <= 1'b0;
      clr_pend_q <= 1'b0;
      frm_q      <= '0;
      clr_sync_q <= '0;
      vs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_vld_q <= hold_vld_d;
      din_q      <= din_d;
      sel_q      <= sel_d;
      prio_q     <= prio_d;
      clr_pend_q <= clr_pend_d;
      frm_q      <= frm_d;
      clr_sync_q <= {clr_sync_q[1:0], clr_req_i};
      if (cpu_wr)        hold_q <= cpu_data_i;
      if (pixel_clken_i) vs_q   <= vsync_i;
    end
  end

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push)        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop & sel_q) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, pop & sel_q})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge sys_clock) begin
    if (push) mem[wr_ptr_q] <= inj_data_i;
  end

endmodule

// File: tb/tb_display_tx_ctrl.sv
module tb_display_tx_ctrl;

  logic       sys_clock;
  logic       reset;
  logic       pixel_clken, cpu_clken, cpu_we, inj_valid, clr_req, vsync, disp_ready;
  logic [7:0] cpu_data, inj_data;
  logic       cpu_ready, inj_ready, disp_address, disp_w_en, disp_clr, busy;
  logic [7:0] disp_din;

  int checks   = 0;
  int failures = 0;
  int acc_cnt  = 0;
  logic [7:0] exp_q [$];

  display_tx_ctrl #(.FIFO_AW(4), .CLR_FRAMES(2)) dut (
    .sys_clock     (sys_clock),
    .reset         (reset),
    .pixel_clken_i (pixel_clken),
    .cpu_clken_i   (cpu_clken),
    .cpu_we_i      (cpu_we),
    .cpu_data_i    (cpu_data),
    .cpu_ready_o   (cpu_ready),
    .inj_valid_i   (inj_valid),
    .inj_data_i    (inj_data),
    .inj_ready_o   (inj_ready),
    .clr_req_i     (clr_req),
    .vsync_i       (vsync),
    .disp_ready_i  (disp_ready),
    .disp_address_o(disp_address),
    .disp_w_en_o   (disp_w_en),
    .disp_din_o    (disp_din),
    .disp_clr_o    (disp_clr),
    .busy_o        (busy)
  );

  initial begin
    sys_clock = 1'b0;
    forever #5 sys_clock = ~sys_clock;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp_v);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: every display accept pops the next expected character.
  always @(negedge sys_clock) begin
    if (!reset && pixel_clken && cpu_clken && disp_w_en && disp_ready) begin
      acc_cnt++;
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL accept_unexpected observed=0x%0h expected=none", disp_din);
      end
      if (exp_q.size() > 0) chk8("accept_char", disp_din, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge sys_clock);
    #1;
  endtask

  task automatic cpu_write(input logic [7:0] d);
    cpu_we = 1'b1; cpu_data = d;
    tick();
    cpu_we = 1'b0;
  endtask

  task automatic inj_push(input logic [7:0] d);
    inj_valid = 1'b1; inj_data = d;
    tick();
    inj_valid = 1'b0;
  endtask

  task automatic accept_one(input string tag);
    int start = acc_cnt;
    int n = 0;
    disp_ready = 1'b1;
    while (acc_cnt == start && n < 20) begin
      tick();
      n++;
    end
    disp_ready = 1'b0;
    chk1(tag, acc_cnt != start, 1'b1);
  endtask

  task automatic clr_pulse();
    clr_req = 1'b1;
    tick(); tick();
    clr_req = 1'b0;
  endtask

  task automatic wait_clr(input string tag);
    int n = 0;
    while (!disp_clr && n < 20) begin
      tick();
      n++;
    end
    chk1(tag, disp_clr, 1'b1);
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    tick(); tick();
    vsync = 1'b0;
    tick(); tick();
  endtask

  initial begin
    reset = 1'b1;
    pixel_clken = 1'b1; cpu_clken = 1'b1; cpu_we = 1'b0; inj_valid = 1'b0;
    clr_req = 1'b0; vsync = 1'b0; disp_ready = 1'b0; cpu_data = '0; inj_data = '0;
    tick(); tick();
    chk1("rst_cpu_ready", cpu_ready, 1'b1);
    chk1("rst_inj_ready", inj_ready, 1'b1);
    chk1("rst_address", disp_address, 1'b1);
    chk1("rst_w_en", disp_w_en, 1'b0);
    chk8("rst_din", disp_din, 8'h00);
    chk1("rst_clr", disp_clr, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick();

    // CPU write is ignored without cpu_clken
    cpu_clken = 1'b0;
    cpu_write(8'h99);
    cpu_clken = 1'b1;
    chk1("cpu_we_no_clken", cpu_ready, 1'b1);
    tick();
    chk1("no_clken_idle", busy, 1'b0);

    // Single CPU character
    exp_q.push_back(8'hC1);
    cpu_write(8'hC1);
    chk1("t1_cpu_ready_low", cpu_ready, 1'b0);
    tick();
    chk1("t1_w_en", disp_w_en, 1'b1);
    chk8("t1_din", disp_din, 8'hC1);
    chk1("t1_address", disp_address, 1'b0);
    chk1("t1_busy", busy, 1'b1);
    pixel_clken = 1'b0;
    disp_ready = 1'b1;
    tick(); tick(); tick();
    chk1("t1_hold_no_pixclk", disp_w_en, 1'b1);
    chki("t1_no_accept", acc_cnt, 0);
    pixel_clken = 1'b1;
    accept_one("t1_accept");
    chk1("t1_cpu_ready_high", cpu_ready, 1'b1);
    chk1("t1_w_en_drop", disp_w_en, 1'b0);
    chk1("t1_address_drop", disp_address, 1'b1);

    // Round-robin from reset: CPU wins the first tie
    reset = 1'b1; tick(); reset = 1'b0; tick();
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    cpu_we = 1'b1; cpu_data = 8'h31; inj_valid = 1'b1; inj_data = 8'h41;
    tick();
    cpu_we = 1'b0; inj_valid = 1'b0;
    inj_push(8'h42);
    accept_one("t2_acc_cpu");
    accept_one("t2_acc_a");
    accept_one("t2_acc_b");
    exp_q.push_back(8'h43);
    exp_q.push_back(8'h32);
    cpu_we = 1'b1; cpu_data = 8'h32; inj_valid = 1'b1; inj_data = 8'h43;
    tick();
    cpu_we = 1'b0; inj_valid = 1'b0;
    accept_one("t2_acc_fifo_tie");
    accept_one("t2_acc_cpu_after");
    chki("t2_sb_empty", exp_q.size(), 0);

    // Fill the FIFO to capacity
    for (int i = 0; i < 15; i++) begin
      exp_q.push_back(8'h50 + 8'(i));
      inj_push(8'h50 + 8'(i));
    end
    chk1("t3_ready_at_15", inj_ready, 1'b1);
    exp_q.push_back(8'h5F);
    inj_push(8'h5F);
    chk1("t3_full_at_16", inj_ready, 1'b0);
    inj_push(8'hFF);
    chk1("t3_still_full", inj_ready, 1'b0);
    for (int i = 0; i < 16; i++) accept_one("t3_accept");
    tick();
    chk1("t3_drained_ready", inj_ready, 1'b1);
    chk1("t3_drained_idle", busy, 1'b0);
    chki("t3_sb_empty", exp_q.size(), 0);

    // Clear aborts a presented char and flushes both sources
    cpu_write(8'h77);
    tick();
    chk1("t4_presenting", disp_w_en, 1'b1);
    inj_push(8'h51);
    clr_pulse();
    wait_clr("t4_enter_clear");
    chk1("t4_w_en_off", disp_w_en, 1'b0);
    chk1("t4_inj_ready_off", inj_ready, 1'b0);
    chk1("t4_cpu_ready_off", cpu_ready, 1'b0);
    chk1("t4_busy", busy, 1'b1);
    vsync_pulse();
    vsync_pulse();
    chk1("t4_clr_after_edge2", disp_clr, 1'b1);
    vsync = 1'b1;
    tick();
    chk1("t4_clr_off_edge3", disp_clr, 1'b0);
    vsync = 1'b0;
    chk1("t4_cpu_ready_exit", cpu_ready, 1'b1);
    chk1("t4_inj_ready_exit", inj_ready, 1'b1);
    tick(); tick();
    chk1("t4_flushed_idle", busy, 1'b0);

    // A second clear edge during frame 1 restarts the count
    clr_pulse();
    wait_clr("t5_enter_clear");
    vsync_pulse();
    clr_pulse();
    tick(); tick(); tick(); tick();
    vsync_pulse();
    vsync_pulse();
    chk1("t5_clr_held", disp_clr, 1'b1);
    vsync = 1'b1;
    tick();
    chk1("t5_clr_off", disp_clr, 1'b0);
    vsync = 1'b0;
    tick();

    // Reset mid-clear takes effect without a clock edge
    clr_pulse();
    wait_clr("t6_enter_clear");
    reset = 1'b1;
    #1;
    chk1("t6_clr_async", disp_clr, 1'b0);
    chk1("t6_busy_async", busy, 1'b0);
    chk1("t6_cpu_ready_async", cpu_ready, 1'b1);
    tick();
    reset = 1'b0;
    tick();
    chk1("t6_idle_after", busy, 1'b0);
    chki("end_sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
